// File: rtl/imm_gen_pipe.sv
// Registered RV32I/RV64I immediate generator for decode.
// Instructions are decoded on acceptance and held in a two-entry OUT/SKID buffer.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm_out,
    output logic [2:0]       fmt_out,
    output logic             illegal_out,
    output logic [CNT_W-1:0] illegal_cnt
);

    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $fatal(1, "imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    localparam bit RV64 = (XLEN == 64);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_ISH = 3'd2;
    localparam logic [2:0] FMT_S   = 3'd3;
    localparam logic [2:0] FMT_B   = 3'd4;
    localparam logic [2:0] FMT_U   = 3'd5;
    localparam logic [2:0] FMT_J   = 3'd6;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            ill;
    } entry_t;

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    state_t           state_q, state_d;
    entry_t           out_q, out_d, skid_q, skid_d, dec;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, emit;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_shift;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j, sh_w, sh_x;

    assign opcode   = inst_code[6:0];
    assign funct3   = inst_code[14:12];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    // Signed casts sign-extend from bit 31 of the instruction to XLEN.
    assign imm_i = XLEN'($signed(inst_code[31:20]));
    assign imm_s = XLEN'($signed({inst_code[31:25], inst_code[11:7]}));
    assign imm_b = XLEN'($signed({inst_code[31], inst_code[7], inst_code[30:25],
                                  inst_code[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({inst_code[31:12], 12'b0}));
    assign imm_j = XLEN'($signed({inst_code[31], inst_code[19:12], inst_code[20],
                                  inst_code[30:21], 1'b0}));
    // Word shifts always use a 5-bit shamt; native shifts use 6 bits on RV64.
    assign sh_w  = XLEN'(inst_code[24:20]);
    assign sh_x  = RV64 ? XLEN'(inst_code[25:20]) : sh_w;

    always_comb begin
        dec = '0;
        unique case (opcode)
            7'b0000011, 7'b1100111, 7'b0001111, 7'b1110011: begin
                dec.fmt = FMT_I;
                dec.imm = imm_i;
            end
            7'b0010011: begin
                dec.fmt = is_shift ? FMT_ISH : FMT_I;
                dec.imm = is_shift ? sh_x : imm_i;
            end
            7'b0011011: begin
                if (RV64) begin
                    dec.fmt = is_shift ? FMT_ISH : FMT_I;
                    dec.imm = is_shift ? sh_w : imm_i;
                end else begin
                    dec.ill = 1'b1;
                end
            end
            7'b0100011: begin
                dec.fmt = FMT_S;
                dec.imm = imm_s;
            end
            7'b1100011: begin
                dec.fmt = FMT_B;
                dec.imm = imm_b;
            end
            7'b0110111, 7'b0010111: begin
                dec.fmt = FMT_U;
                dec.imm = imm_u;
            end
            7'b1101111: begin
                dec.fmt = FMT_J;
                dec.imm = imm_j;
            end
            7'b0110011: dec.fmt = FMT_R;
            7'b0111011: dec.ill = !RV64;
            default:    dec.ill = 1'b1;
        endcase
    end

    assign accept = in_valid && in_ready_q;
    assign emit   = (state_q != S_EMPTY) && out_ready;

    // in_ready_q is 0 whenever state is TWO, so accept never fires there.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    out_d   = dec;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (accept && !emit) begin
                    skid_d  = dec;
                    state_d = S_TWO;
                end else if (accept && emit) begin
                    out_d   = dec;
                end else if (emit) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (emit) begin
                    out_d   = skid_q;
                    state_d = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        if (accept && dec.ill && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
        in_ready_d = (state_d != S_TWO);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_EMPTY;
            out_q      <= '0;
            skid_q     <= '0;
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            out_q      <= out_d;
            skid_q     <= skid_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = (state_q != S_EMPTY);
    assign imm_out     = out_q.imm;
    assign fmt_out     = out_q.fmt;
    assign illegal_out = out_q.ill;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: three instances (RV32, RV32 with 2-bit
// counter, RV64) share one stimulus stream.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] inst_code;
    logic        out_ready;

    logic        rdy_a, vld_a, ill_a;
    logic [31:0] imm_a;
    logic [2:0]  fmt_a;
    logic [15:0] cnt_a;

    logic        rdy_b, vld_b, ill_b;
    logic [31:0] imm_b;
    logic [2:0]  fmt_b;
    logic [1:0]  cnt_b;

    logic        rdy_c, vld_c, ill_c;
    logic [63:0] imm_c;
    logic [2:0]  fmt_c;
    logic [15:0] cnt_c;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_a),
        .inst_code(inst_code), .out_valid(vld_a), .out_ready(out_ready),
        .imm_out(imm_a), .fmt_out(fmt_a), .illegal_out(ill_a), .illegal_cnt(cnt_a));

    imm_gen_pipe #(.XLEN(32), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_b),
        .inst_code(inst_code), .out_valid(vld_b), .out_ready(out_ready),
        .imm_out(imm_b), .fmt_out(fmt_b), .illegal_out(ill_b), .illegal_cnt(cnt_b));

    imm_gen_pipe #(.XLEN(64), .CNT_W(16)) dut_c (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy_c),
        .inst_code(inst_code), .out_valid(vld_c), .out_ready(out_ready),
        .imm_out(imm_c), .fmt_out(fmt_c), .illegal_out(ill_c), .illegal_cnt(cnt_c));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] v_inst [6];
    logic [31:0] v_imm  [6];
    logic [2:0]  v_fmt  [6];

    initial begin
        v_inst = '{32'hFFF00093, 32'h00309093, 32'hFE20AE23,
                   32'h123452B7, 32'hFF9FF06F, 32'h00000863};
        v_imm  = '{32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFC,
                   32'h12345000, 32'hFFFFFFF8, 32'h00000010};
        v_fmt  = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd6, 3'd4};

        reset     = 1'b1;
        in_valid  = 1'b0;
        inst_code = 32'h0;
        out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;

        chk("rst_out_valid", vld_a, 0);
        chk("rst_in_ready", rdy_a, 1);
        chk("rst_imm", imm_a, 0);
        chk("rst_fmt", fmt_a, 0);
        chk("rst_ill", ill_a, 0);
        chk("rst_cnt", cnt_a, 0);

        // Back-to-back stream, one result per cycle.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        inst_code = v_inst[0];
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("stream_vld%0d", i), vld_a, 1);
            chk($sformatf("stream_imm%0d", i), imm_a, v_imm[i]);
            chk($sformatf("stream_fmt%0d", i), fmt_a, v_fmt[i]);
            chk($sformatf("stream_rdy%0d", i), rdy_a, 1);
            if (i < 5) inst_code = v_inst[i+1];
            else       in_valid  = 1'b0;
        end
        chk("stream_neg_imm64", imm_c, 64'h0000000000000010);
        step();
        chk("stream_drain_vld", vld_a, 0);

        // Backpressure: two accepted, third stalls, OUT held stable.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        inst_code = 32'h00100093;
        step();
        chk("bp_rdy_one", rdy_a, 1);
        chk("bp_imm_a", imm_a, 1);
        inst_code = 32'h00200093;
        step();
        chk("bp_rdy_two", rdy_a, 0);
        for (int i = 0; i < 10; i++) begin
            inst_code = 32'h00000013 | (32'(i + 5) << 20) | (i[0] ? 32'h00000010 : 32'h0);
            step();
            chk($sformatf("stab_imm%0d", i), imm_a, 1);
            chk($sformatf("stab_fmt%0d", i), fmt_a, 1);
            chk($sformatf("stab_ill%0d", i), ill_a, 0);
            chk($sformatf("stab_rdy%0d", i), rdy_a, 0);
        end
        inst_code = 32'h00300093;
        out_ready = 1'b1;
        step();
        chk("bp_out_b", imm_a, 2);
        chk("bp_rdy_back", rdy_a, 1);
        step();
        chk("bp_out_c", imm_a, 3);
        chk("bp_out_c_vld", vld_a, 1);
        in_valid = 1'b0;
        step();
        chk("bp_drain_vld", vld_a, 0);

        // Illegal opcodes and counter saturation.
        in_valid  = 1'b1;
        inst_code = 32'h0000007F;
        step();
        chk("ill_flag", ill_a, 1);
        chk("ill_imm", imm_a, 0);
        chk("ill_fmt", fmt_a, 0);
        chk("ill_cnt1", cnt_a, 1);
        repeat (4) step();
        chk("ill_cnt5", cnt_a, 5);
        chk("ill_sat", cnt_b, 3);

        // addiw: legal on RV64 only.
        inst_code = 32'h0010809B;
        step();
        chk("addiw32_ill", ill_a, 1);
        chk("addiw32_cnt", cnt_a, 6);
        chk("addiw_sat_hold", cnt_b, 3);
        chk("addiw64_ill", ill_c, 0);
        chk("addiw64_imm", imm_c, 1);
        chk("addiw64_fmt", fmt_c, 1);

        inst_code = 32'h03F09093;
        step();
        chk("slli64_imm", imm_c, 64'h3F);
        chk("slli64_fmt", fmt_c, 2);
        chk("slli32_imm", imm_a, 32'h1F);

        inst_code = 32'hFFF00093;
        step();
        chk("addi64_neg", imm_c, 64'hFFFFFFFFFFFFFFFF);
        chk("cnt64", cnt_c, 5);

        // Async reset while full and stalled.
        out_ready = 1'b0;
        inst_code = 32'h00500093;
        step();
        inst_code = 32'h00600093;
        step();
        chk("mid_rdy_two", rdy_a, 0);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_vld", vld_a, 0);
        chk("mid_rst_imm", imm_a, 0);
        chk("mid_rst_cnt", cnt_a, 0);
        in_valid = 1'b0;
        step();
        reset     = 1'b0;
        out_ready = 1'b1;
        step();
        chk("mid_post_rdy", rdy_a, 1);
        chk("mid_post_vld", vld_a, 0);
        step();
        chk("mid_no_stale", vld_a, 0);
        chk("mid_no_stale_imm", imm_a, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, parametrised immediate generator for the decode stage. Covers all RV32I/RV64I immediate formats: I, I-shift, S, B, U, J.
- Also reports the format class and an illegal-opcode flag, and keeps a saturating count of illegal opcodes.
- Uses a valid/ready handshake on both sides with a 2-entry skid buffer. This gives full throughput while `in_ready` comes from a flop.
- Sits between the fetch/instruction register and the control/ALU-operand mux.

Parameters:
- `XLEN`, default 32: datapath width, 32 or 64. Immediates are sign-extended to `XLEN`. Any other value is a fatal elaboration error.
- `CNT_W`, default 16: width of the saturating illegal-opcode counter.

Ports:
- `clk`, in, 1: clock, rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: `inst_code` is valid.
- `in_ready`, out, 1: block can accept. Registered.
- `inst_code`, in, 32: instruction word.
- `out_valid`, out, 1: outputs hold a decoded entry.
- `out_ready`, in, 1: consumer accepts.
- `imm_out`, out, XLEN: sign-extended immediate.
- `fmt_out`, out, 3: 0=R/none, 1=I, 2=I-shift, 3=S, 4=B, 5=U, 6=J.
- `illegal_out`, out, 1: opcode not recognised.
- `illegal_cnt`, out, CNT_W: saturating count of illegal opcodes accepted.

Behaviour:
- Reset (async assert, sync deassert): all of the following are 0 — `out_valid`, `imm_out`, `fmt_out`, `illegal_out`, `illegal_cnt`, both buffer entries. `in_ready` is 1.
- Reset mid-operation discards all buffered entries; no partial output.
- Accept when `in_valid && in_ready`. Emit when `out_valid && out_ready`.
- Latency: 1 cycle. An instruction accepted in cycle N appears in cycle N+1 if the output stage was empty or emitting in cycle N.
- Throughput: one instruction per cycle while `out_ready=1`.
- Storage: output register (OUT) plus skid register (SKID). States are EMPTY, ONE (OUT valid), TWO (OUT and SKID valid).
  - EMPTY: accept → ONE.
  - ONE: accept and no emit → TWO (entry goes to SKID). Emit and no accept → EMPTY. Accept and emit → ONE (OUT reloads).
  - TWO: `in_ready=0`. Emit → ONE (SKID moves to OUT).
- `in_ready` is registered and equals "not TWO next cycle". Order is always preserved.
- `out_valid` = state ≠ EMPTY. OUT holds its value stable while `out_valid && !out_ready`.
- Decode, by `opcode = inst_code[6:0]`; `sext(x)` = sign-extend to `XLEN` from bit 31:
  - `0000011` (load), `1100111` (jalr), `0001111` (fence), `1110011` (system): I, `imm = sext(inst[31:20])`.
  - `0010011` (op-imm) with `funct3` = 001 or 101: I-shift. `imm` = zero-extended shamt, `inst[24:20]` when XLEN=32, `inst[25:20]` when XLEN=64.
  - `0010011` with any other `funct3`: I, `imm = sext(inst[31:20])`.
  - `0011011` (op-imm-32): legal only when XLEN=64. Same rules as `0010011`, but shamt is always `inst[24:20]`. When XLEN=32 it is illegal.
  - `0100011`: S, `imm = sext({inst[31:25], inst[11:7]})`.
  - `1100011`: B, `imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0})`.
  - `0110111`, `0010111`: U, `imm = sext({inst[31:12], 12'b0})`.
  - `1101111`: J, `imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0})`.
  - `0110011`, `0111011` (the latter only when XLEN=64): R, `imm = 0`.
  - Anything else: illegal. Set `fmt_out = 0`, `imm = 0`, `illegal_out = 1`.
- Decode is performed at acceptance; entries are stored already decoded.
- `illegal_cnt` increments by 1 on each accepted illegal instruction. It holds at all-ones and does not wrap.

Test Plan:
- Reset, then `out_ready=1`. Send `0xFFF00093`, `0x00309093`, `0xFE20AE23`, `0x123452B7`, `0xFF9FF06F`, `0x00000863` on back-to-back cycles. Required `imm_out` one cycle after each accept: `0xFFFFFFFF`/fmt 1, `0x3`/fmt 2, `0xFFFFFFFC`/fmt 3, `0x12345000`/fmt 5, `0xFFFFFFF8`/fmt 6, `0x10`/fmt 4. `out_valid` stays high for 6 consecutive cycles.
- Backpressure: `out_ready=0`, drive 3 valid instructions. First two accepted, `in_ready` drops to 0 after the second, third is stalled. Set `out_ready=1` → outputs appear in order, one per cycle, and `in_ready` returns to 1.
- Illegal: send `0x0000007F` → `illegal_out=1`, `imm_out=0`, `fmt_out=0`, `illegal_cnt=1`. With `CNT_W=2`, 5 illegal instructions → `illegal_cnt` holds at 3.
- XLEN=64: `0x03F09093` (slli shamt 63) → `imm_out=0x3F`, fmt 2. `0xFFF00093` → `imm_out=0xFFFFFFFFFFFFFFFF`. `0x0010809B` (addiw) is legal. Same `0x0010809B` with XLEN=32 → illegal.
- Reset mid-operation: buffer in TWO state with `out_ready=0`, then assert `reset` asynchronously mid-cycle. Outputs go to 0 immediately, `in_ready=1` after deassert, and no stale entry is emitted afterwards.
- Stability: hold `out_ready=0` for 10 cycles while toggling `inst_code`. `imm_out`, `fmt_out` and `illegal_out` do not change.
